// File: rtl/dsp_seq_pkg.sv
// dsp_seq_pkg: shared types and constants for the DSP MAC sequencer.
//   seq_state_t : sequencer FSM states
//   FB_ACC      : tile feedback select for accumulate mode
//   DSP_*_W     : 20x18 tile operand / result / shift widths
package dsp_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } seq_state_t;

    localparam logic [2:0] FB_ACC = 3'b000;

    localparam int DSP_A_W     = 20;
    localparam int DSP_B_W     = 18;
    localparam int DSP_Z_W     = 38;
    localparam int DSP_SHIFT_W = 6;

endpackage

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: drives one 20x18 DSP tile through a dot-product job.
//   job      : start_i, len_i, shift_i/round_i/saturate_i/subtract_i/unsigned_*_i
//   operands : op_valid_i / op_ready_o / op_a_i / op_b_i
//   tile     : dsp_a_o, dsp_b_o, dsp_feedback_o, dsp_load_acc_o, mode outputs, dsp_z_i
//   result   : res_valid_o / res_ready_i / res_data_o
//   status   : busy_o (not IDLE)
// Reset is asynchronous active-low on reset_i.
module dsp_mac_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int MAX_TERMS   = 64,
    parameter int DSP_LATENCY = 1,
    parameter int LEN_W       = $clog2(MAX_TERMS + 1)
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [LEN_W-1:0]       len_i,
    input  logic [DSP_SHIFT_W-1:0] shift_i,
    input  logic                   round_i,
    input  logic                   saturate_i,
    input  logic                   subtract_i,
    input  logic                   unsigned_a_i,
    input  logic                   unsigned_b_i,
    output logic                   busy_o,
    input  logic                   op_valid_i,
    output logic                   op_ready_o,
    input  logic [DSP_A_W-1:0]     op_a_i,
    input  logic [DSP_B_W-1:0]     op_b_i,
    output logic [DSP_A_W-1:0]     dsp_a_o,
    output logic [DSP_B_W-1:0]     dsp_b_o,
    output logic [2:0]             dsp_feedback_o,
    output logic                   dsp_load_acc_o,
    output logic [DSP_SHIFT_W-1:0] dsp_shift_right_o,
    output logic                   dsp_round_o,
    output logic                   dsp_saturate_enable_o,
    output logic                   dsp_subtract_o,
    output logic                   dsp_unsigned_a_o,
    output logic                   dsp_unsigned_b_o,
    input  logic [DSP_Z_W-1:0]     dsp_z_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [DSP_Z_W-1:0]     res_data_o
);

    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_TERMS);
    localparam logic [1:0]       DRAIN_END = 2'(DSP_LATENCY - 1);

    seq_state_t             state_q, state_d;
    logic [LEN_W-1:0]       cnt_q, cnt_d;
    logic                   first_q, first_d;
    logic [1:0]             drain_q, drain_d;
    logic [DSP_A_W-1:0]     a_q, a_d;
    logic [DSP_B_W-1:0]     b_q, b_d;
    logic                   load_acc_q, load_acc_d;
    logic [DSP_SHIFT_W-1:0] shift_q, shift_d;
    logic                   round_q, round_d;
    logic                   sat_q, sat_d;
    logic                   sub_q, sub_d;
    logic                   ua_q, ua_d;
    logic                   ub_q, ub_d;
    logic                   res_valid_q, res_valid_d;
    logic [DSP_Z_W-1:0]     res_data_q, res_data_d;
    logic [LEN_W-1:0]       len_c;
    logic                   xfer;

    assign len_c = (len_i > MAX_LEN) ? MAX_LEN : len_i;
    assign xfer  = op_valid_i && (state_q == ACCUM);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        drain_d     = drain_q;
        // Zero operands with load_acc=1 make every non-transfer cycle a no-op add.
        a_d         = '0;
        b_d         = '0;
        load_acc_d  = 1'b1;
        shift_d     = shift_q;
        round_d     = round_q;
        sat_d       = sat_q;
        sub_d       = sub_q;
        ua_d        = ua_q;
        ub_d        = ub_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        unique case (state_q)
            IDLE: begin
                load_acc_d = load_acc_q;
                if (start_i) begin
                    shift_d = shift_i;
                    round_d = round_i;
                    sat_d   = saturate_i;
                    sub_d   = subtract_i;
                    ua_d    = unsigned_a_i;
                    ub_d    = unsigned_b_i;
                    cnt_d   = len_c;
                    first_d = 1'b1;
                    if (len_c == '0) begin
                        state_d     = HOLD;
                        res_data_d  = '0;
                        res_valid_d = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (xfer) begin
                    a_d        = op_a_i;
                    b_d        = op_b_i;
                    // First term overwrites whatever the tile accumulator holds.
                    load_acc_d = !first_q;
                    first_d    = 1'b0;
                    cnt_d      = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_END) begin
                    state_d     = HOLD;
                    res_data_d  = dsp_z_i;
                    res_valid_d = 1'b1;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            HOLD: begin
                if (res_ready_i) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            drain_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            load_acc_q  <= 1'b0;
            shift_q     <= '0;
            round_q     <= 1'b0;
            sat_q       <= 1'b0;
            sub_q       <= 1'b0;
            ua_q        <= 1'b0;
            ub_q        <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            drain_q     <= drain_d;
            a_q         <= a_d;
            b_q         <= b_d;
            load_acc_q  <= load_acc_d;
            shift_q     <= shift_d;
            round_q     <= round_d;
            sat_q       <= sat_d;
            sub_q       <= sub_d;
            ua_q        <= ua_d;
            ub_q        <= ub_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign busy_o                = (state_q != IDLE);
    assign op_ready_o            = (state_q == ACCUM);
    assign dsp_a_o               = a_q;
    assign dsp_b_o               = b_q;
    assign dsp_feedback_o        = FB_ACC;
    assign dsp_load_acc_o        = load_acc_q;
    assign dsp_shift_right_o     = shift_q;
    assign dsp_round_o           = round_q;
    assign dsp_saturate_enable_o = sat_q;
    assign dsp_subtract_o        = sub_q;
    assign dsp_unsigned_a_o      = ua_q;
    assign dsp_unsigned_b_o      = ub_q;
    assign res_valid_o           = res_valid_q;
    assign res_data_o            = res_data_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer paired with a behavioural signed MAC
// tile (latency 1: z reflects the current a/b by the end of the cycle).
module tb_dsp_mac_sequencer;

    localparam int MAX_TERMS   = 4;
    localparam int DSP_LATENCY = 1;
    localparam int LEN_W       = $clog2(MAX_TERMS + 1);

    logic              clock_i = 1'b0;
    logic              reset_i;
    logic              start_i;
    logic [LEN_W-1:0]  len_i;
    logic [5:0]        shift_i;
    logic              round_i, saturate_i, subtract_i, unsigned_a_i, unsigned_b_i;
    logic              busy_o;
    logic              op_valid_i, op_ready_o;
    logic [19:0]       op_a_i;
    logic [17:0]       op_b_i;
    logic [19:0]       dsp_a_o;
    logic [17:0]       dsp_b_o;
    logic [2:0]        dsp_feedback_o;
    logic              dsp_load_acc_o;
    logic [5:0]        dsp_shift_right_o;
    logic              dsp_round_o, dsp_saturate_enable_o, dsp_subtract_o;
    logic              dsp_unsigned_a_o, dsp_unsigned_b_o;
    logic [37:0]       dsp_z_i;
    logic              res_valid_o, res_ready_i;
    logic [37:0]       res_data_o;

    int checks = 0;
    int errors = 0;

    always #5 clock_i = ~clock_i;

    dsp_mac_sequencer #(.MAX_TERMS(MAX_TERMS), .DSP_LATENCY(DSP_LATENCY)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .len_i(len_i),
        .shift_i(shift_i), .round_i(round_i), .saturate_i(saturate_i),
        .subtract_i(subtract_i), .unsigned_a_i(unsigned_a_i), .unsigned_b_i(unsigned_b_i),
        .busy_o(busy_o), .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .dsp_a_o(dsp_a_o), .dsp_b_o(dsp_b_o),
        .dsp_feedback_o(dsp_feedback_o), .dsp_load_acc_o(dsp_load_acc_o),
        .dsp_shift_right_o(dsp_shift_right_o), .dsp_round_o(dsp_round_o),
        .dsp_saturate_enable_o(dsp_saturate_enable_o), .dsp_subtract_o(dsp_subtract_o),
        .dsp_unsigned_a_o(dsp_unsigned_a_o), .dsp_unsigned_b_o(dsp_unsigned_b_o),
        .dsp_z_i(dsp_z_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_data_o(res_data_o)
    );

    // Behavioural tile: accumulator is not touched by the sequencer reset.
    logic [37:0] acc_q, prod_c, sum_c;
    assign prod_c  = {{18{dsp_a_o[19]}}, dsp_a_o} * {{20{dsp_b_o[17]}}, dsp_b_o};
    assign sum_c   = (dsp_load_acc_o ? acc_q : 38'd0) + prod_c;
    assign dsp_z_i = 38'($signed(sum_c) >>> dsp_shift_right_o);
    always @(posedge clock_i) acc_q <= sum_c;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic start_job(input logic [LEN_W-1:0] len, input logic [5:0] sh, input logic exp_ready);
        start_i = 1'b1;
        len_i   = len;
        shift_i = sh;
        tick();
        start_i = 1'b0;
        len_i   = '0;
        shift_i = '0;
        chk("start_busy", busy_o, 1);
        chk("start_op_ready", op_ready_o, exp_ready);
    endtask

    task automatic send(input logic [19:0] a, input logic [17:0] b, input logic exp_load);
        int n = 0;
        op_valid_i = 1'b1;
        op_a_i     = a;
        op_b_i     = b;
        while (!op_ready_o && n < 20) begin
            tick();
            n++;
        end
        chk("op_ready_wait", (n < 20), 1);
        tick();
        op_valid_i = 1'b0;
        op_a_i     = '0;
        op_b_i     = '0;
        chk("dsp_a", dsp_a_o, a);
        chk("dsp_b", dsp_b_o, b);
        chk("dsp_load_acc", dsp_load_acc_o, exp_load);
    endtask

    task automatic wait_result(input string tag, input logic [37:0] exp, input int exp_lat);
        int n = 0;
        while (!res_valid_o && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_data"}, res_data_o, exp);
    endtask

    task automatic handshake();
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        chk("hs_busy", busy_o, 0);
        chk("hs_valid", res_valid_o, 0);
    endtask

    task automatic dot4();
        start_job(3'd4, 6'd0, 1'b1);
        send(20'd1, 18'd5, 1'b0);
        send(20'd2, 18'd6, 1'b1);
        send(20'd3, 18'd7, 1'b1);
        send(20'd4, 18'd8, 1'b1);
        chk("drain_op_ready", op_ready_o, 0);
    endtask

    initial begin
        reset_i = 1'b0; start_i = 1'b0; len_i = '0; shift_i = '0;
        round_i = 1'b0; saturate_i = 1'b0; subtract_i = 1'b0;
        unsigned_a_i = 1'b0; unsigned_b_i = 1'b0;
        op_valid_i = 1'b0; op_a_i = '0; op_b_i = '0; res_ready_i = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_op_ready", op_ready_o, 0);
        chk("rst_res_valid", res_valid_o, 0);
        chk("rst_res_data", res_data_o, 0);
        chk("rst_load_acc", dsp_load_acc_o, 0);
        chk("rst_dsp_a", dsp_a_o, 0);
        chk("rst_feedback", dsp_feedback_o, 0);
        reset_i = 1'b1;
        tick();

        // Sum of products: 5+12+21+32 = 70
        dot4();
        wait_result("sop", 38'd70, DSP_LATENCY);
        handshake();

        // Signed: -15 + 4 = -11
        start_job(3'd2, 6'd0, 1'b1);
        send(20'hFFFFD, 18'd5, 1'b0);
        send(20'd2, 18'd2, 1'b1);
        wait_result("signed", 38'h3F_FFFF_FFF5, DSP_LATENCY);
        handshake();

        // Gapped stream: bubbles carry zero operands with load_acc=1
        start_job(3'd4, 6'd0, 1'b1);
        send(20'd1, 18'd5, 1'b0);
        tick();
        chk("bubble_a", dsp_a_o, 0);
        chk("bubble_b", dsp_b_o, 0);
        chk("bubble_load", dsp_load_acc_o, 1);
        repeat (2) tick();
        send(20'd2, 18'd6, 1'b1);
        repeat (3) tick();
        send(20'd3, 18'd7, 1'b1);
        repeat (3) tick();
        send(20'd4, 18'd8, 1'b1);
        wait_result("gapped", 38'd70, DSP_LATENCY);
        handshake();

        // Backpressure with a start pulse in HOLD: 3*4 = 12
        start_job(3'd1, 6'd0, 1'b1);
        send(20'd3, 18'd4, 1'b0);
        wait_result("bp", 38'd12, DSP_LATENCY);
        for (int i = 0; i < 5; i++) begin
            start_i = (i == 1);
            len_i   = (i == 1) ? 3'd2 : 3'd0;
            tick();
            chk("bp_valid", res_valid_o, 1);
            chk("bp_data", res_data_o, 12);
        end
        start_i = 1'b0;
        len_i   = '0;
        handshake();
        tick();
        chk("bp_no_job_busy", busy_o, 0);
        chk("bp_no_job_ready", op_ready_o, 0);

        // Zero-length job: result 0 at T+1, no operand acceptance
        start_job(3'd0, 6'd0, 1'b0);
        chk("zero_valid", res_valid_o, 1);
        chk("zero_data", res_data_o, 0);
        handshake();

        // Shift: 16*1 >> 2 = 4
        start_job(3'd1, 6'd2, 1'b1);
        chk("shift_cfg_start", dsp_shift_right_o, 2);
        send(20'd16, 18'd1, 1'b0);
        chk("shift_cfg_mid", dsp_shift_right_o, 2);
        wait_result("shift", 38'd4, DSP_LATENCY);
        chk("shift_cfg_end", dsp_shift_right_o, 2);
        handshake();

        // Length above MAX_TERMS is clamped to 4 terms: 2+3+4+5 = 14
        start_job(3'd7, 6'd0, 1'b1);
        send(20'd1, 18'd2, 1'b0);
        send(20'd1, 18'd3, 1'b1);
        send(20'd1, 18'd4, 1'b1);
        send(20'd1, 18'd5, 1'b1);
        chk("clamp_op_ready", op_ready_o, 0);
        wait_result("clamp", 38'd14, DSP_LATENCY);
        handshake();

        // Reset mid-job after 2 of 4 terms; outputs clear asynchronously
        start_job(3'd4, 6'd3, 1'b1);
        send(20'd1, 18'd5, 1'b0);
        send(20'd2, 18'd6, 1'b1);
        #2;
        reset_i = 1'b0;
        #1;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_ready", op_ready_o, 0);
        chk("mid_rst_a", dsp_a_o, 0);
        chk("mid_rst_load", dsp_load_acc_o, 0);
        chk("mid_rst_shift", dsp_shift_right_o, 0);
        chk("mid_rst_valid", res_valid_o, 0);
        tick();
        reset_i = 1'b1;
        tick();
        dot4();
        wait_result("after_rst", 38'd70, DSP_LATENCY);
        handshake();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
